// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: posted write buffer between the L1 dcache memory port and L2/memory
// Ports: clk, rst_n (async, active-low); up_* is the L1 strobe / one-cycle ready-pulse side;
//        dn_* is the held-request memory side; wb_count/wb_empty report buffer occupancy.
module dcache_write_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        up_addr,
    input  logic                         up_rd,
    input  logic                         up_wr,
    input  logic [DATA_WIDTH-1:0]        up_wdata,
    output logic [DATA_WIDTH-1:0]        up_rdata,
    output logic                         up_ready,
    output logic [ADDR_WIDTH-1:0]        dn_addr,
    output logic                         dn_rd,
    output logic                         dn_wr,
    output logic [DATA_WIDTH-1:0]        dn_wdata,
    input  logic [DATA_WIDTH-1:0]        dn_rdata,
    input  logic                         dn_ready,
    output logic [$clog2(DEPTH+1)-1:0]   wb_count,
    output logic                         wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d, idx, hit_idx, cidx;
    logic [CW-1:0]         count_q, count_d;
    logic                  pw_valid_q, pr_valid_q, up_ready_q;
    logic [ADDR_WIDTH-1:0] pw_addr_q, pr_addr_q, dn_addr_q, enq_addr;
    logic [DATA_WIDTH-1:0] pw_data_q, dn_wdata_q, up_rdata_q, enq_data, head_wdata;
    logic                  acc, wr_s, rd_s, full, hit, chit, coal, wr_new, pop, pw_enq, enq;
    logic                  rd_hit, rd_miss, rd_done;
    // Youngest match wins: scan oldest to youngest so later matches override.
    // The in-flight head is readable but must not be coalesced into.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        chit    = 1'b0;
        cidx    = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && addr_q[idx] == up_addr) begin
                hit     = 1'b1;
                hit_idx = idx;
                if (!(i == 0 && state_q == DRAIN)) begin
                    chit = 1'b1;
                    cidx = idx;
                end
            end
        end
    end
    assign acc      = !pw_valid_q && !pr_valid_q;
    assign wr_s     = acc && up_wr;
    assign rd_s     = acc && up_rd && !up_wr;
    assign full     = count_q == CW'(DEPTH);
    assign coal     = wr_s && chit;
    assign wr_new   = wr_s && !chit;
    assign pop      = state_q == DRAIN && dn_ready;
    assign rd_done  = state_q == READ && dn_ready;
    assign pw_enq   = pw_valid_q && !full;
    assign enq      = (wr_new && !full) || pw_enq;
    assign enq_addr = pw_valid_q ? pw_addr_q : up_addr;
    assign enq_data = pw_valid_q ? pw_data_q : up_wdata;
    assign rd_hit   = rd_s && hit;
    assign rd_miss  = rd_s && !hit;
    assign head_d   = pop ? head_q + PW'(1) : head_q;
    assign tail_d   = enq ? tail_q + PW'(1) : tail_q;
    assign count_d  = count_q + CW'(enq) - CW'(pop);
    // A coalesce into the head in the cycle the drain launches must reach memory.
    assign head_wdata = (coal && cidx == head_q) ? up_wdata : data_q[head_q];
    assign state_d = state_q == IDLE  ? ((pr_valid_q || rd_miss) ? READ : (count_q != '0 ? DRAIN : IDLE)) :
                     state_q == DRAIN ? (dn_ready ? IDLE : DRAIN) :
                                        (dn_ready ? IDLE : READ);
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= enq_addr;
            data_q[tail_q] <= enq_data;
        end
        if (coal) data_q[cidx] <= up_wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pw_valid_q <= 1'b0;
            pw_addr_q  <= '0;
            pw_data_q  <= '0;
            pr_valid_q <= 1'b0;
            pr_addr_q  <= '0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            up_ready_q <= 1'b0;
            up_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (state_q == IDLE && state_d == DRAIN) begin
                dn_addr_q  <= addr_q[head_q];
                dn_wdata_q <= head_wdata;
            end
            if (state_q == IDLE && state_d == READ) dn_addr_q <= pr_valid_q ? pr_addr_q : up_addr;
            if (wr_new && full) begin
                pw_valid_q <= 1'b1;
                pw_addr_q  <= up_addr;
                pw_data_q  <= up_wdata;
            end else if (pw_enq) begin
                pw_valid_q <= 1'b0;
            end
            if (rd_miss) begin
                pr_valid_q <= 1'b1;
                pr_addr_q  <= up_addr;
            end else if (rd_done) begin
                pr_valid_q <= 1'b0;
            end
            up_ready_q <= (wr_s && (chit || !full)) || pw_enq || rd_hit || rd_done;
            up_rdata_q <= rd_hit ? data_q[hit_idx] : rd_done ? dn_rdata : up_rdata_q;
        end
    end
    assign dn_rd    = state_q == READ;
    assign dn_wr    = state_q == DRAIN;
    assign dn_addr  = dn_addr_q;
    assign dn_wdata = dn_wdata_q;
    assign up_ready = up_ready_q;
    assign up_rdata = up_rdata_q;
    assign wb_count = count_q;
    assign wb_empty = count_q == '0;
endmodule
